// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks a one-cold column drive, locks onto the first pressed key,
// debounces press and release, and hands one hex code per press to a valid/ready consumer.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES   = 4800,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        state, state_next;
    logic [3:0]    rows_meta, rows_s;
    logic [1:0]    col_idx, col_next;
    logic [1:0]    lock_row, lock_row_next;
    logic [1:0]    low_row;
    logic [SW-1:0] settle_cnt, settle_next;
    logic [DW-1:0] deb_cnt, deb_next;
    logic          locked_low;
    logic          emit;
    logic          accept;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Synchronizer resets to the released level so no phantom press appears after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta <= '1;
            rows_s    <= '1;
        end else begin
            rows_meta <= rows_n;
            rows_s    <= rows_meta;
        end
    end

    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) low_row = 2'(i);
        end
    end

    assign locked_low = !rows_s[lock_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCAN;
            col_idx    <= 2'd0;
            lock_row   <= 2'd0;
            settle_cnt <= '0;
            deb_cnt    <= '0;
        end else begin
            state      <= state_next;
            col_idx    <= col_next;
            lock_row   <= lock_row_next;
            settle_cnt <= settle_next;
            deb_cnt    <= deb_next;
        end
    end

    // col_idx stays on the locked column outside SCAN, which keeps the drive frozen there.
    always_comb begin
        state_next    = state;
        col_next      = col_idx;
        lock_row_next = lock_row;
        settle_next   = settle_cnt;
        deb_next      = deb_cnt;
        emit          = 1'b0;
        case (state)
            SCAN: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_next = '0;
                    if (rows_s != 4'hF) begin
                        lock_row_next = low_row;
                        deb_next      = '0;
                        state_next    = DEBOUNCE;
                    end else begin
                        col_next = col_idx + 2'd1;
                    end
                end else begin
                    settle_next = settle_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!locked_low) begin
                    state_next  = SCAN;
                    col_next    = col_idx + 2'd1;
                    settle_next = '0;
                end else if (deb_cnt == DEBOUNCE_LAST) begin
                    state_next = HELD;
                    deb_next   = '0;
                    emit       = 1'b1;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (locked_low) begin
                    deb_next = '0;
                end else if (deb_cnt == DEBOUNCE_LAST) begin
                    state_next  = SCAN;
                    col_next    = col_idx + 2'd1;
                    settle_next = '0;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    assign accept = key_valid & key_ready;

    // A consumer accepting in the same cycle frees the slot, so the new press is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!key_valid || accept) begin
                key_valid <= 1'b1;
                key_code  <= key_map(lock_row, col_idx);
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            key_valid <= 1'b0;
        end
    end

    assign cols_n   = ~(4'b0001 << col_idx);
    assign key_held = (state != SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a behavioural keypad matrix drives rows_n from
// cols_n, and expected key codes are queued at press time and popped when the DUT offers them.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_ready;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       overrun;

    logic       pressed [4][4];
    logic [3:0] exp_q [$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows_n   (rows_n),
        .cols_n   (cols_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .overrun  (overrun)
    );

    // A row reads low when a pressed key in that row sits on a column driven low.
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !cols_n[c]) rows_n[r] = 1'b0;
            end
        end
    end

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && key_valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic wait_held(input logic level, input int limit);
        for (int i = 0; i < limit && key_held !== level; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        key_ready = 1'b0;
        release_all();
        repeat (3) @(negedge clk);
        total++; if (cols_n !== 4'b1110) begin bad++; $display("[TB] FAIL reset_cols got=%b want=1110", cols_n); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL reset_held got=%b want=0", key_held); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got=%b want=0", overrun); end
        total++; if (key_code !== 4'h0) begin bad++; $display("[TB] FAIL reset_code got=%h want=0", key_code); end
    endtask

    task automatic test_scan();
        logic [3:0] want;
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            want = ~(4'b0001 << ((k / 4) % 4));
            total++; if (cols_n !== want) begin bad++; $display("[TB] FAIL scan_cols step=%0d got=%b want=%b", k, cols_n, want); end
            total++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin bad++; $display("[TB] FAIL scan_idle step=%0d got valid=%b held=%b want 0/0", k, key_valid, key_held); end
            @(negedge clk);
        end
    endtask

    task automatic test_single_event();
        int drops;
        int rises;
        logic [3:0] want;
        pressed[1][2] = 1'b1;
        exp_q.push_back(4'h6);
        wait_valid(100);
        total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid_rise got=%b want=1", key_valid); end
        total++; if (key_held !== 1'b1) begin bad++; $display("[TB] FAIL single_held got=%b want=1", key_held); end
        drops = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b1) drops++;
        end
        total++; if (drops != 0) begin bad++; $display("[TB] FAIL single_valid_hold got drops=%0d want=0", drops); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL single_no_second got overrun=%b want=0", overrun); end
        key_ready = 1'b1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        total++; if (key_code !== want) begin bad++; $display("[TB] FAIL single_code got=%h want=%h", key_code, want); end
        @(negedge clk);
        key_ready = 1'b0;
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_clear got=%b want=0", key_valid); end
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) rises++;
        end
        total++; if (rises != 0) begin bad++; $display("[TB] FAIL single_no_repeat got=%0d want=0", rises); end
        total++; if (key_code !== 4'h6) begin bad++; $display("[TB] FAIL single_code_hold got=%h want=6", key_code); end
        pressed[1][2] = 1'b0;
        wait_held(1'b0, 60);
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL single_release got held=%b want=0", key_held); end
    endtask

    task automatic test_bounce();
        int rises;
        pressed[0][0] = 1'b1;
        wait_held(1'b1, 60);
        total++; if (key_held !== 1'b1) begin bad++; $display("[TB] FAIL bounce_lock got held=%b want=1", key_held); end
        pressed[0][0] = 1'b0;
        wait_held(1'b0, 20);
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL bounce_abort got held=%b want=0", key_held); end
        total++; if (cols_n !== 4'b1101) begin bad++; $display("[TB] FAIL bounce_next_col got=%b want=1101", cols_n); end
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) rises++;
        end
        total++; if (rises != 0) begin bad++; $display("[TB] FAIL bounce_no_event got=%0d want=0", rises); end
    endtask

    task automatic test_overrun();
        logic [3:0] want;
        pressed[0][0] = 1'b1;
        exp_q.push_back(4'h1);
        wait_valid(100);
        total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_first_valid got=%b want=1", key_valid); end
        pressed[0][0] = 1'b0;
        wait_held(1'b0, 60);
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL ovr_first_release got held=%b want=0", key_held); end
        pressed[0][1] = 1'b1;
        for (int i = 0; i < 100 && overrun !== 1'b1; i++) @(negedge clk);
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag got=%b want=1", overrun); end
        total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_valid_kept got=%b want=1", key_valid); end
        key_ready = 1'b1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        total++; if (key_code !== want) begin bad++; $display("[TB] FAIL ovr_code got=%h want=%h", key_code, want); end
        @(negedge clk);
        key_ready = 1'b0;
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_valid_clear got=%b want=0", key_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky got=%b want=1", overrun); end
        pressed[0][1] = 1'b0;
        wait_held(1'b0, 60);
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL ovr_second_release got held=%b want=0", key_held); end
    endtask

    task automatic test_multi_row();
        logic [3:0] want;
        pressed[0][1] = 1'b1;
        pressed[1][1] = 1'b1;
        exp_q.push_back(4'h2);
        wait_valid(100);
        total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL multi_valid got=%b want=1", key_valid); end
        key_ready = 1'b1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        total++; if (key_code !== want) begin bad++; $display("[TB] FAIL multi_code got=%h want=%h", key_code, want); end
        @(negedge clk);
        key_ready = 1'b0;
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL multi_valid_clear got=%b want=0", key_valid); end
        pressed[0][1] = 1'b0;
        pressed[1][1] = 1'b0;
        wait_held(1'b0, 60);
        total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL multi_release got held=%b want=0", key_held); end
    endtask

    task automatic test_held_ignore();
        logic [3:0] want;
        int rises;
        int moved;
        pressed[1][1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_valid(100);
        total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold5_valid got=%b want=1", key_valid); end
        key_ready = 1'b1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        total++; if (key_code !== want) begin bad++; $display("[TB] FAIL hold5_code got=%h want=%h", key_code, want); end
        @(negedge clk);
        key_ready = 1'b0;
        pressed[0][3] = 1'b1;
        rises = 0;
        moved = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) rises++;
            if (cols_n !== 4'b1101) moved++;
        end
        total++; if (rises != 0) begin bad++; $display("[TB] FAIL hold_ignore_event got=%0d want=0", rises); end
        total++; if (moved != 0) begin bad++; $display("[TB] FAIL hold_cols_frozen got=%0d want=0", moved); end
        total++; if (key_held !== 1'b1) begin bad++; $display("[TB] FAIL hold_held got=%b want=1", key_held); end
        pressed[1][1] = 1'b0;
        exp_q.push_back(4'hA);
        wait_valid(150);
        total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL holdA_valid got=%b want=1", key_valid); end
        key_ready = 1'b1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        total++; if (key_code !== want) begin bad++; $display("[TB] FAIL holdA_code got=%h want=%h", key_code, want); end
        @(negedge clk);
        key_ready = 1'b0;
        pressed[0][3] = 1'b0;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) rises++;
        end
        total++; if (rises != 0) begin bad++; $display("[TB] FAIL holdA_single got=%0d want=0", rises); end
    endtask

    task automatic test_reset_midway();
        int rises;
        pressed[0][2] = 1'b1;
        wait_held(1'b1, 60);
        total++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_deb_reach got held=%b valid=%b want 1/0", key_held, key_valid); end
        reset = 1'b1;
        release_all();
        @(negedge clk);
        total++; if (cols_n !== 4'b1110) begin bad++; $display("[TB] FAIL rst_deb_cols got=%b want=1110", cols_n); end
        total++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_deb_flags got held=%b valid=%b want 0/0", key_held, key_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL rst_deb_overrun got=%b want=0", overrun); end
        reset = 1'b0;
        pressed[2][2] = 1'b1;
        wait_valid(100);
        total++; if (key_valid !== 1'b1 || key_held !== 1'b1) begin bad++; $display("[TB] FAIL rst_held_reach got valid=%b held=%b want 1/1", key_valid, key_held); end
        total++; if (key_code !== 4'h9) begin bad++; $display("[TB] FAIL rst_held_code got=%h want=9", key_code); end
        reset = 1'b1;
        release_all();
        @(negedge clk);
        total++; if (cols_n !== 4'b1110) begin bad++; $display("[TB] FAIL rst_held_cols got=%b want=1110", cols_n); end
        total++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_held_flags got held=%b valid=%b want 0/0", key_held, key_valid); end
        total++; if (key_code !== 4'h0 || overrun !== 1'b0) begin bad++; $display("[TB] FAIL rst_held_regs got code=%h overrun=%b want 0/0", key_code, overrun); end
        reset = 1'b0;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) rises++;
        end
        total++; if (rises != 0) begin bad++; $display("[TB] FAIL rst_no_event got=%0d want=0", rises); end
    endtask

    task automatic test_scoreboard_drained();
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_event();
        test_bounce();
        test_overrun();
        test_multi_row();
        test_held_ignore();
        test_reset_midway();
        test_scoreboard_drained();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
